// File: rtl/alu_pkg.sv
// Shared ALU types.
//   alu_op_t    : 8-bit ALU operation select
//   flags_t     : Game Boy F register layout (Z N H C in bits 7..4, low nibble always 0)
//   alu16_op_t  : 16-bit operation select for the alu16_seq sequencer
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP
  } alu_op_t;

  typedef struct packed {
    logic       z;
    logic       n;
    logic       h;
    logic       c;
    logic [3:0] rsvd;
  } flags_t;

  typedef enum logic [1:0] {
    ADD_HL, ADD_SP, INC16, DEC16
  } alu16_op_t;

endpackage

// File: rtl/alu8.sv
// Shared 8-bit combinational ALU.
//   en        in  : drive enable; outputs are 0 when low
//   op        in  : operation
//   a, b      in  : operands
//   flags_in  in  : incoming flags (only C is used, as carry/borrow for ADC/SBC)
//   res       out : 8-bit result (CP returns a unchanged)
//   flags     out : Z N H C for the operation
module alu8
  import alu_pkg::*;
(
  input  logic       en,
  input  alu_op_t    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  flags_t     flags_in,
  output logic [7:0] res,
  output flags_t     flags
);

  logic       w_cin;
  logic [4:0] w_nib;
  logic [8:0] w_sum;

  always_comb begin
    w_cin = 1'b0;
    w_nib = '0;
    w_sum = '0;
    res   = '0;
    flags = '0;
    if (op == ALU_ADC || op == ALU_SBC) w_cin = flags_in.c;
    case (op)
      ALU_ADD, ALU_ADC: begin
        w_nib   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, w_cin};
        w_sum   = {1'b0, a} + {1'b0, b} + {8'b0, w_cin};
        res     = w_sum[7:0];
        flags.h = w_nib[4];
        flags.c = w_sum[8];
      end
      ALU_SUB, ALU_SBC, ALU_CP: begin
        // bit 4 / bit 8 of the widened difference is the borrow
        w_nib   = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, w_cin};
        w_sum   = {1'b0, a} - {1'b0, b} - {8'b0, w_cin};
        res     = (op == ALU_CP) ? a : w_sum[7:0];
        flags.n = 1'b1;
        flags.h = w_nib[4];
        flags.c = w_sum[8];
      end
      ALU_AND: begin
        res     = a & b;
        flags.h = 1'b1;
      end
      ALU_XOR: res = a ^ b;
      ALU_OR:  res = a | b;
      default: res = '0;
    endcase
    flags.z = (op == ALU_CP) ? (w_sum[7:0] == 8'h00) : (res == 8'h00);
    if (!en) begin
      res   = '0;
      flags = '0;
    end
  end

endmodule

// File: rtl/alu16_seq.sv
// Two-step 16-bit arithmetic sequencer on the shared 8-bit ALU.
// Runs the low byte, then the high byte with the carry chained through
// ADC/SBC, and assembles the 16-bit result with Game Boy flag rules.
//   clk, rst_n           : clock, synchronous active-low reset
//   start/op16/opa/opb/flags_in : request (accepted when ready=1)
//   ready, done          : idle/complete status; done is a 1-cycle pulse
//   res16, flags_out     : result and flags, held until the next result
//   alu_req/alu_gnt      : ALU port arbitration
//   alu_en/op/a/b/flags_in : ALU drive (combinational from state + latches)
//   alu_res/alu_flags    : ALU combinational outputs
module alu16_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  alu16_op_t   op16,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  flags_t      flags_in,
  output logic        ready,
  output logic        done,
  output logic [15:0] res16,
  output flags_t      flags_out,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic        alu_en,
  output alu_op_t     alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output flags_t      alu_flags_in,
  input  logic [7:0]  alu_res,
  input  flags_t      alu_flags
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      r_state;
  alu16_op_t   r_op;
  logic [15:0] r_a, r_b;
  flags_t      r_fin;
  logic [7:0]  r_lo;
  logic        r_lo_h, r_lo_c;
  logic [15:0] r_res16;
  flags_t      r_flags_out;
  logic        r_ready, r_done;
  flags_t      w_flags_hi;

  // ALU drive: purely from state and latched operands, never from start
  always_comb begin
    alu_req      = 1'b0;
    alu_op       = ALU_ADD;
    alu_a        = '0;
    alu_b        = '0;
    alu_flags_in = '0;
    case (r_state)
      S_LO: begin
        alu_req        = 1'b1;
        alu_a          = r_a[7:0];
        alu_flags_in   = r_fin;
        alu_flags_in.c = 1'b0;
        case (r_op)
          ADD_HL, ADD_SP: alu_b = r_b[7:0];
          INC16:          alu_b = 8'h01;
          default: begin
            alu_b  = 8'h01;
            alu_op = ALU_SUB;
          end
        endcase
      end
      S_HI: begin
        alu_req        = 1'b1;
        alu_a          = r_a[15:8];
        alu_flags_in   = r_fin;
        alu_flags_in.c = r_lo_c;
        alu_op         = ALU_ADC;
        case (r_op)
          ADD_HL:  alu_b = r_b[15:8];
          ADD_SP:  alu_b = {8{r_b[7]}};  // sign extension of e8
          INC16:   alu_b = 8'h00;
          default: alu_op = ALU_SBC;
        endcase
      end
      default: ;
    endcase
  end

  assign alu_en = alu_req & alu_gnt;

  // ADD HL takes H/C from the high byte; ADD SP from the low byte
  always_comb begin
    w_flags_hi = r_fin;
    case (r_op)
      ADD_HL: begin
        w_flags_hi   = '0;
        w_flags_hi.z = r_fin.z;
        w_flags_hi.h = alu_flags.h;
        w_flags_hi.c = alu_flags.c;
      end
      ADD_SP: begin
        w_flags_hi   = '0;
        w_flags_hi.h = r_lo_h;
        w_flags_hi.c = r_lo_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= ADD_HL;
      r_a         <= '0;
      r_b         <= '0;
      r_fin       <= '0;
      r_lo        <= '0;
      r_lo_h      <= 1'b0;
      r_lo_c      <= 1'b0;
      r_res16     <= '0;
      r_flags_out <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_op    <= op16;
            r_a     <= opa;
            r_b     <= opb;
            r_fin   <= flags_in;
            r_state <= S_LO;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_LO: if (alu_gnt) begin
          r_lo    <= alu_res;
          r_lo_h  <= alu_flags.h;
          r_lo_c  <= alu_flags.c;
          r_state <= S_HI;
        end
        S_HI: if (alu_gnt) begin
          r_res16     <= {alu_res, r_lo};
          r_flags_out <= w_flags_hi;
          r_state     <= S_DONE;
          r_done      <= 1'b1;
          r_ready     <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign res16     = r_res16;
  assign flags_out = r_flags_out;

endmodule
